mux_scan_sched: RTL and testbench

//  Scan controller for the 256x4 packed word multiplexer. On a start pulse it walks the

---
 rtl/mux_sched_pkg.sv | 16 +
 rtl/mux_word_sel.sv | 21 ++
 rtl/mux_scan_sched.sv | 149 ++++++++++++++
 tb/tb_mux_scan_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types and defaults for the packed-word scan scheduler.
//   sched_state_t : scan controller state encoding
//   N_WORDS_DEF   : default number of packed words
//   W_DEF         : default bits per word
package mux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int N_WORDS_DEF = 256;
  localparam int W_DEF       = 4;

endpackage

// File: rtl/mux_word_sel.sv
// Combinational N_WORDS:1 selector over a packed word vector.
//   in_flat : N_WORDS*W packed words, word i = in_flat[i*W +: W]
//   sel     : word index
//   word    : selected word
module mux_word_sel
  import mux_sched_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int W       = W_DEF,
  parameter int IDX_W   = $clog2(N_WORDS)
) (
  input  logic [N_WORDS*W-1:0] in_flat,
  input  logic [IDX_W-1:0]     sel,
  output logic [W-1:0]         word
);

  always_comb begin
    word = in_flat[int'(sel)*W +: W];
  end

endmodule

// File: rtl/mux_scan_sched.sv
// Scan controller for a packed word multiplexer. A start pulse walks the
// select index 0..N_WORDS-1, skipping words whose snapshotted mask bit is
// clear, and emits each enabled word as an (index, data) beat on a
// valid/ready stream.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a scan (honoured only when idle, and not with abort)
//   abort      : terminate a running scan, dropping any unaccepted beat
//   mask       : word enables, captured at start
//   in_flat    : packed words, held stable by the caller while busy
//   out_valid / out_ready / out_idx / out_data : beat stream
//   busy       : scan or drain in progress
//   done       : one-cycle pulse on normal completion
module mux_scan_sched
  import mux_sched_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int W       = W_DEF,
  parameter int IDX_W   = $clog2(N_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_WORDS-1:0]   mask,
  input  logic [N_WORDS*W-1:0] in_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [W-1:0]         out_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [N_WORDS-1:0]   mask_q, mask_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [W-1:0]         ptr_word;
  logic                 slot_free;

  mux_word_sel #(
    .N_WORDS (N_WORDS),
    .W       (W),
    .IDX_W   (IDX_W)
  ) u_word_sel (
    .in_flat (in_flat),
    .sel     (ptr_q),
    .word    (ptr_word)
  );

  // The output register can take a new beat when it is empty or its
  // current beat is being accepted this cycle.
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SCAN;
          mask_d  = mask;
          ptr_d   = '0;
        end
      end

      SCAN: begin
        // abort wins over a same-cycle handshake: that beat is dropped.
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (slot_free) begin
          if (mask_q[ptr_q]) begin
            out_valid_d = 1'b1;
            out_idx_d   = ptr_q;
            out_data_d  = ptr_word;
          end else begin
            out_valid_d = 1'b0;
          end
          // ptr wraps to 0 after the last index; its value is unused in DRAIN.
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (slot_free) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_sched.sv
module tb_mux_scan_sched;

  localparam int N     = 256;
  localparam int W     = 4;
  localparam int IDX_W = 8;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     data;
  } beat_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [N-1:0]       mask;
  logic [N*W-1:0]     in_flat;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_idx;
  logic [W-1:0]       out_data;
  logic               busy;
  logic               done;

  beat_t q[$];
  int n_tests;
  int n_fail;

  mux_scan_sched #(
    .N_WORDS (N),
    .W       (W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mask      (mask),
    .in_flat   (in_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int i);
    return in_flat[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one scan from start to done, scoring every accepted beat.
  // rmode 0: ready always high; rmode 1: ready pattern 1,0,0,1,0,0,...
  task automatic run_scan(input string tag, input logic [N-1:0] m, input int rmode,
                          input int exp_lat, input int max_cyc);
    int lat;
    int first_k;
    int beats;
    int exp_beats;
    logic stalled;
    logic [IDX_W-1:0] pidx;
    logic [W-1:0] pdata;
    beat_t b;
    q.delete();
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        b.idx  = IDX_W'(i);
        b.data = word_of(i);
        q.push_back(b);
      end
    end
    exp_beats = q.size();
    lat = -1; first_k = -1; beats = 0; stalled = 1'b0; pidx = '0; pdata = '0;
    mask = m;
    start = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= max_cyc && lat < 0; k++) begin
      tick();
      start = 1'b0;
      mask = ~m;  // must not affect the running scan
      if (out_valid === 1'b1 && first_k < 0) first_k = k;
      if (stalled) begin
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_idx"}, 32'(out_idx), 32'(pidx));
        chk({tag, "_stall_data"}, 32'(out_data), 32'(pdata));
      end
      out_ready = (rmode == 0) ? 1'b1 : (k % 3 == 0);
      if (out_valid === 1'b1 && out_ready) begin
        beats++;
        if (q.size() == 0) begin
          chk({tag, "_unexpected_beat"}, 32'(out_idx), 32'hFFFF_FFFF);
        end else begin
          b = q.pop_front();
          chk({tag, "_idx"}, 32'(out_idx), 32'(b.idx));
          chk({tag, "_data"}, 32'(out_data), 32'(b.data));
        end
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      pidx = out_idx;
      pdata = out_data;
      if (done === 1'b1) lat = k;
    end
    chk({tag, "_done_seen"}, 32'(lat > 0), 32'd1);
    if (exp_lat >= 0) chk({tag, "_done_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_beat_count"}, 32'(beats), 32'(exp_beats));
    if (m[0] && rmode == 0) chk({tag, "_first_beat_cycle"}, 32'(first_k), 32'd2);
    chk({tag, "_valid_at_done"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse_once"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N-1:0] m;
    logic found;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    mask = '0; in_flat = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: all enabled, word i = i mod 16, ready high
    for (int i = 0; i < N; i++) in_flat[i*W +: W] = W'(i);
    run_scan("t1_full", {N{1'b1}}, 0, 258, 400);

    // 2: sparse mask {3,200,255}, random data
    for (int i = 0; i < N; i++) in_flat[i*W +: W] = W'($urandom);
    m = '0; m[3] = 1'b1; m[200] = 1'b1; m[255] = 1'b1;
    run_scan("t2_sparse", m, 0, 258, 400);

    // 3: all enabled, ready toggling 1,0,0,...
    run_scan("t3_backpressure", {N{1'b1}}, 1, -1, 2000);

    // 4: empty mask
    run_scan("t4_empty", '0, 0, 258, 400);

    // 5: abort at idx 100 while stalled with a valid beat
    mask = {N{1'b1}};
    start = 1'b1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      start = 1'b0;
      if (out_valid === 1'b1 && out_idx == 8'd100) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reach_idx100", 32'(found), 32'd1);
    out_ready = 1'b0;
    tick();
    chk("t5_stall_valid", 32'(out_valid), 32'd1);
    chk("t5_stall_idx", 32'(out_idx), 32'd100);
    chk("t5_stall_data", 32'(out_data), 32'(word_of(100)));
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_idle_done", 32'(done), 32'd0);
      chk("t5_idle_valid", 32'(out_valid), 32'd0);
    end
    m = N'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    m[0] = 1'b1;
    run_scan("t5_rescan", m, 0, 258, 400);

    // 6: reset mid-scan at idx 50, then start together with abort in IDLE
    mask = {N{1'b1}};
    start = 1'b1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      start = 1'b0;
      if (out_valid === 1'b1 && out_idx == 8'd50) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reach_idx50", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_idx", 32'(out_idx), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t6_startabort_busy", 32'(busy), 32'd0);
      chk("t6_startabort_valid", 32'(out_valid), 32'd0);
      chk("t6_startabort_done", 32'(done), 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
